// File: rtl/rc4_ksa_if.sv
// rc4_ksa_if: run request, key and S-memory port bundle for rc4_ksa
interface rc4_ksa_if #(
  parameter int KEY_BYTES = 3,
  parameter int ADDR_W    = 8
);
  logic                   start;
  logic [8*KEY_BYTES-1:0] secret_key;
  logic [ADDR_W-1:0]      mem_addr;
  logic [ADDR_W-1:0]      mem_wdata;
  logic                   mem_wr_en;
  logic [ADDR_W-1:0]      mem_rdata;
  logic                   task_on;
  logic                   fin_strobe;
  modport master (
    input  start, secret_key, mem_rdata,
    output mem_addr, mem_wdata, mem_wr_en, task_on, fin_strobe
  );
  modport slave (
    output start, secret_key, mem_rdata,
    input  mem_addr, mem_wdata, mem_wr_en, task_on, fin_strobe
  );
endinterface

// File: rtl/rc4_ksa.sv
// rc4_ksa: RC4 key-scheduling over an external S-memory; define RC4_KSA_INIT_EN to build the S[i]=i fill phase
module rc4_ksa #(
  parameter int KEY_BYTES = 3,
  parameter int ADDR_W    = 8
) (
  input  logic           clk,
  input  logic           rst,
  rc4_ksa_if.master      bus
);
  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);
  localparam logic [ADDR_W-1:0] I_LAST = '1;
  typedef enum logic [2:0] {
    IDLE,
`ifdef RC4_KSA_INIT_EN
    INIT,
`endif
    RD_I,
    RD_J,
    WAIT_J,
    WR_I,
    WR_J,
    DONE
  } state_t;
  state_t                 state_q, state_d;
  logic [ADDR_W-1:0]      i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [KW-1:0]          k_q, k_d;
  logic [8*KEY_BYTES-1:0] key_q, key_d;
  logic [ADDR_W-1:0]      kb, j_new;
  // next-state, datapath updates and memory port drive
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    si_d = si_q;
    sj_d = sj_q;
    k_d = k_q;
    key_d = key_q;
    bus.mem_addr = '0;
    bus.mem_wdata = '0;
    bus.mem_wr_en = 1'b0;
    bus.task_on = state_q != IDLE;
    bus.fin_strobe = state_q == DONE;
    kb = key_q[8*(KEY_BYTES-1-int'(k_q)) +: ADDR_W];
    j_new = j_q + bus.mem_rdata + kb;
    case (state_q)
      IDLE: if (bus.start) begin
        key_d = bus.secret_key;
        i_d = '0;
        j_d = '0;
        k_d = '0;
`ifdef RC4_KSA_INIT_EN
        state_d = INIT;
`else
        state_d = RD_I;
`endif
      end
`ifdef RC4_KSA_INIT_EN
      INIT: begin
        bus.mem_addr = i_q;
        bus.mem_wdata = i_q;
        bus.mem_wr_en = 1'b1;
        i_d = i_q + 1'b1;
        state_d = (i_q == I_LAST) ? RD_I : INIT;
      end
`endif
      RD_I: begin
        bus.mem_addr = i_q;
        state_d = RD_J;
      end
      RD_J: begin
        si_d = bus.mem_rdata;
        j_d = j_new;
        bus.mem_addr = j_new;
        state_d = WAIT_J;
      end
      WAIT_J: begin
        sj_d = bus.mem_rdata;
        state_d = WR_I;
      end
      WR_I: begin
        bus.mem_addr = i_q;
        bus.mem_wdata = sj_q;
        bus.mem_wr_en = 1'b1;
        state_d = WR_J;
      end
      WR_J: begin
        bus.mem_addr = j_q;
        bus.mem_wdata = si_q;
        bus.mem_wr_en = 1'b1;
        k_d = (k_q == K_LAST) ? '0 : k_q + 1'b1;
        i_d = (i_q == I_LAST) ? i_q : i_q + 1'b1;
        state_d = (i_q == I_LAST) ? DONE : RD_I;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      i_q <= '0;
      j_q <= '0;
      si_q <= '0;
      sj_q <= '0;
      k_q <= '0;
      key_q <= '0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      si_q <= si_d;
      sj_q <= sj_d;
      k_q <= k_d;
      key_q <= key_d;
    end
  end
endmodule

// File: doc/rc4_ksa.md
RC4_KSA -- requirements
Module: rc4_ksa

Interface
REQ-001 Parameter KEY_BYTES, default 3: secret key length in bytes, legal range 1..32.
REQ-002 Parameter ADDR_W, default 8: S-memory address and data width; DEPTH = 2^ADDR_W; legal range 2..8.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  request to run; sampled only in IDLE.
REQ-006 secret_key  in  8*KEY_BYTES  key; byte 0 = secret_key[8*KEY_BYTES-1 -: 8].
REQ-007 mem_addr  out  ADDR_W  S-memory address.
REQ-008 mem_wdata  out  ADDR_W  S-memory write data.
REQ-009 mem_wr_en  out  1  S-memory write enable.
REQ-010 mem_rdata  in  ADDR_W  S-memory read data, valid one cycle after mem_addr is presented.
REQ-011 task_on  out  1  high while the block is running, including the DONE cycle.
REQ-012 fin_strobe  out  1  one-cycle completion pulse.

Function
REQ-013 States: IDLE, INIT, RD_I, RD_J, WAIT_J, WR_I, WR_J, DONE.
REQ-014 IDLE: if start=1, latch secret_key into an internal register, clear i and j, and go to INIT; otherwise stay in IDLE.
REQ-015 INIT: write S[i]=i, one write per cycle, for i=0..DEPTH-1; after i=DEPTH-1, clear i and go to RD_I.
REQ-016 RD_I: mem_addr=i, mem_wr_en=0.
REQ-017 RD_J: latch si=mem_rdata; j_new = (j + mem_rdata + key[i mod KEY_BYTES]) mod DEPTH; mem_addr=j_new; j<=j_new.
REQ-018 WAIT_J: latch sj=mem_rdata.
REQ-019 WR_I: mem_addr=i, mem_wdata=sj, mem_wr_en=1.
REQ-020 WR_J: mem_addr=j, mem_wdata=si, mem_wr_en=1; if i=DEPTH-1 go to DONE, else i<=i+1 and go to RD_I.
REQ-021 Each KSA iteration shall take exactly 5 cycles; when i=j, both writes shall occur and leave S[i] unchanged.
REQ-022 Key byte index shall wrap modulo KEY_BYTES, and that counter shall be independent of ADDR_W.
REQ-023 All index and sum arithmetic shall be modulo DEPTH, i.e. truncated to ADDR_W bits; an 8-bit key byte shall be truncated to ADDR_W bits before addition.
REQ-024 DONE: fin_strobe=1 for exactly one cycle, then return to IDLE.
REQ-025 With INIT compiled in, fin_strobe shall assert 6*DEPTH+1 cycles after the edge at which start was sampled.
REQ-026 start asserted while not in IDLE shall be ignored, with no restart and no queued run; secret_key changes during a run shall have no effect.
REQ-027 mem_wr_en shall be 0 in IDLE, RD_I, RD_J, WAIT_J and DONE.
REQ-028 In IDLE, mem_addr and mem_wdata shall be 0.

Reset
REQ-029 While rst=0 at a clock edge, the block shall enter IDLE with i=j=si=sj=0, mem_wr_en=0, task_on=0, fin_strobe=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset mid-run shall abort without a fin_strobe pulse; memory contents are left as written so far; a later start runs the full sequence.
REQ-031 Reset shall take priority over start in the same cycle.

Configuration
REQ-032 Macro RC4_KSA_INIT_EN defined: the INIT phase is present as in REQ-015; the IDLE-to-INIT transition applies.
REQ-033 Macro RC4_KSA_INIT_EN undefined: the INIT state is not built; IDLE goes directly to RD_I; the memory is required to hold S[i]=i beforehand; fin_strobe asserts 5*DEPTH+1 cycles after start is sampled.

Verification
REQ-034 Basic run: ADDR_W=2, KEY_BYTES=1, key=8'h00, macro defined, start pulsed -> final S=[0,2,3,1]; fin_strobe high for exactly 1 cycle, 25 cycles after start is sampled.
REQ-035 Default config: ADDR_W=8, KEY_BYTES=3, key=24'h000249 -> all 256 entries match a software RC4 KSA model; fin_strobe 1537 cycles after start is sampled.
REQ-036 Busy start: ADDR_W=2 run with start re-pulsed at cycle 10 and again in the DONE cycle -> exactly one fin_strobe; final S=[0,2,3,1].
REQ-037 Reset mid-run: ADDR_W=8, rst=0 for 1 cycle at cycle 700 -> next cycle task_on=0 and mem_wr_en=0, no fin_strobe; a new start gives the full model-correct result after 1537 cycles.
REQ-038 Macro undefined: ADDR_W=2, memory preloaded [0,1,2,3], key=8'h00 -> final S=[0,2,3,1]; fin_strobe 21 cycles after start; no write before the first WR_I.
REQ-039 Key wrap: ADDR_W=8, KEY_BYTES=5, key=40'h0102030405 -> matches the software model; key index observed as 0,1,2,3,4,0 across iterations 0..5.
